cic3_decimator: RTL and testbench
=================================

// Module: cic3_decimator
// PURPOSE
// - Demodulates a 1-bit delta-sigma bitstream (e.g. a 2nd-order modulator output, or an ADC modulator) into
//   signed multi-bit PCM samples.
// - Uses a 3rd-order CIC (sinc^3) decimator with output backpressure.
// - Sits at the receive/loopback end of the DSM chain.
// - AXI-Stream style input (1 bit/beat) and output (WIDTH bits/sample).
// PARAMETERS
// - WIDTH   16  output sample width (signed, two's complement)
// - DECIM   64  decimation ratio R; power of 2, >= 4; 3*log2(DECIM)+1 >= WIDTH required
// PORTS
// - aclk                in   1      single clock, all logic rising-edge
// - arst                in   1      asynchronous, active-high reset
// - s_axis_data_tdata   in   1      bitstream bit: 1 -> +1, 0 -> -1
// - s_axis_data_tvalid  in   1      input bit valid
// - s_axis_data_tready  out  1      input accepted when tvalid&&tready
// - m_axis_data_tdata   out  WIDTH  decimated signed sample
// - m_axis_data_tvalid  out  1      output sample valid
// - m_axis_data_tready  in   1      downstream ready
// - m_axis_data_tsat    out  1      sample was saturated; qualified by tvalid
// BEHAVIOUR
// - Reset (arst=1, async): integrators, comb delays, phase counter, prime counter, m_axis_data_tdata,
//   m_axis_data_tvalid and m_axis_data_tsat all cleared to 0; state=PRIME.
// - Reset released synchronously internally is not required; all regs clear async, run from first edge after release.
// - Widths: LR = log2(DECIM); ACC_W = 3*LR+2; all integrators/combs are ACC_W signed.
//   - Modulo-2^ACC_W wrap-around is intended; no integrator saturation.
// - Accepted beat (s_valid&&s_ready): x = tdata ? +1 : -1, sign-extended to ACC_W.
//   - i1 <= i1 + x; i2 <= i2 + i1; i3 <= i3 + i2 (right-hand sides are pre-edge values).
//   - phase <= (phase==DECIM-1) ? 0 : phase+1.
// - No accepted beat: integrators and phase hold.
// - Decimation event: accepted beat with phase==DECIM-1. Comb stage (combinational off pre-edge i3), then registered:
//   - c1 = i3 - d1; c2 = c1 - d2; c3 = c2 - d3; d1<=i3; d2<=c1; d3<=c2.
// - Scaling: y = c3 >>> (3*LR+1-WIDTH), arithmetic shift.
//   - If y > 2^(WIDTH-1)-1: out = 2^(WIDTH-1)-1, tsat=1.
//   - Else if y < -2^(WIDTH-1): out = -2^(WIDTH-1), tsat=1.
//   - Else out = y[WIDTH-1:0], tsat=0.
// - State machine:
//   - PRIME: the first 3 decimation events after reset update the comb delays but produce no output
//     (prime counter 0..2); on the 3rd event -> RUN.
//   - RUN: each decimation event loads out/tsat into the output register and sets m_tvalid=1 on the same edge
//     (latency: 1 cycle after the completing beat).
// - Output register: m_tvalid clears on m_tvalid&&m_tready unless a new decimation event loads on the same edge
//   (load wins, m_tvalid stays 1). tdata/tsat stable while m_tvalid&&!m_tready.
// - s_axis_data_tready = !(state==RUN && phase==DECIM-1 && m_tvalid && !m_tready).
//   - Stalls only the beat that would overwrite an unconsumed sample; never a combinational path from s_tvalid.
//   - In PRIME, tready=1 always.
// - No sample loss and no duplication under any backpressure pattern.
// - Arst asserted mid-operation: immediate clear of all outputs; pending sample discarded; PRIME restarts.
// TESTING
// - All-ones input, R=64, W=16, m_tready=1: 3 decimation events silent, then every 64th beat
//   out=32767, tsat=1 (c3=2^18).
// - All-zeros input: after PRIME, out=-32768, tsat=0 every sample.
// - Alternating 1,0,... starting with 1: after PRIME, out=0 every sample; first valid output 1 cycle after beat #256.
// - Backpressure: all-ones, hold m_tready=0 for 200 cycles in RUN: tvalid stays 1, data stable,
//   s_tready=0 at phase 63 only. Release: exactly one sample consumed, then stream resumes, no drops.
// - Sparse s_tvalid (random 30% duty): output sample values identical to the dense-input run, sample count equal.
// - Arst pulse mid-block at phase 17 with m_tvalid=1: outputs 0 asynchronously. After release,
//   the first output appears only after 4*64 accepted beats.

Source files
------------

// File: rtl/cic3_decimator_if.sv
// -----------------------------------------------------------------------------
// cic3_decimator_if
// Stream bundle for the sinc^3 bitstream decimator.
//   s_axis_data_*  : 1-bit delta-sigma bitstream in (tdata, tvalid, tready)
//   m_axis_data_*  : WIDTH-bit signed PCM out (tdata, tvalid, tready, tsat)
// Modports:
//   slave  : the decimator side (consumes the bitstream, produces samples)
//   master : the environment side (feeds the bitstream, takes samples)
// -----------------------------------------------------------------------------
interface cic3_decimator_if #(
  parameter int WIDTH = 16
);
  logic             s_axis_data_tdata;
  logic             s_axis_data_tvalid;
  logic             s_axis_data_tready;
  logic [WIDTH-1:0] m_axis_data_tdata;
  logic             m_axis_data_tvalid;
  logic             m_axis_data_tready;
  logic             m_axis_data_tsat;

  modport slave (
    input  s_axis_data_tdata,
    input  s_axis_data_tvalid,
    output s_axis_data_tready,
    output m_axis_data_tdata,
    output m_axis_data_tvalid,
    input  m_axis_data_tready,
    output m_axis_data_tsat
  );

  modport master (
    output s_axis_data_tdata,
    output s_axis_data_tvalid,
    input  s_axis_data_tready,
    input  m_axis_data_tdata,
    input  m_axis_data_tvalid,
    output m_axis_data_tready,
    input  m_axis_data_tsat
  );
endinterface

// File: rtl/cic3_decimator.sv
// -----------------------------------------------------------------------------
// cic3_decimator
// Third-order CIC (sinc^3) decimator turning a 1-bit delta-sigma bitstream
// into signed WIDTH-bit PCM samples, one sample per DECIM accepted bits.
// Ports:
//   aclk  : clock, all logic on the rising edge
//   arst  : asynchronous, active-high reset
//   axis  : stream bundle (slave modport)
//             s_axis_data_tdata  1 -> +1, 0 -> -1
//             m_axis_data_tdata  saturated signed sample, tsat flags clipping
// The first three decimation events after reset only fill the comb delay
// line; samples are emitted from the fourth event on.
// -----------------------------------------------------------------------------
module cic3_decimator #(
  parameter int WIDTH = 16,
  parameter int DECIM = 64
) (
  input logic           aclk,
  input logic           arst,
  cic3_decimator_if.slave axis
);
  localparam int LR    = $clog2(DECIM);
  localparam int ACC_W = 3 * LR + 2;
  // Full-scale comb output is +/-2^(3*LR); keep the top WIDTH bits of that range.
  localparam int SHIFT = 3 * LR + 1 - WIDTH;

  localparam logic [LR-1:0] PHASE_LAST = LR'(DECIM - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t                   state;
  logic [1:0]               prime_cnt;
  logic [LR-1:0]            phase;
  logic signed [ACC_W-1:0]  i1, i2, i3;
  logic signed [ACC_W-1:0]  d1, d2, d3;
  logic signed [ACC_W-1:0]  c1, c2, c3, y, x;
  logic [WIDTH-1:0]         sat_data;
  logic                     sat_flag;
  logic [WIDTH-1:0]         m_data;
  logic                     m_valid;
  logic                     m_sat;
  logic                     s_ready;
  logic                     beat;
  logic                     dec_ev;

  // Only the beat that would complete a block while an unconsumed sample is
  // still held gets stalled; this depends on state and m_tready, not s_tvalid.
  assign s_ready = !(state == RUN && phase == PHASE_LAST &&
                     m_valid && !axis.m_axis_data_tready);
  assign beat    = axis.s_axis_data_tvalid && s_ready;
  assign dec_ev  = beat && (phase == PHASE_LAST);

  // Bipolar input sample; '1 is -1 in two's complement.
  assign x = axis.s_axis_data_tdata ? ACC_W'(1) : '1;

  // Comb section evaluated off the pre-edge integrator output.
  assign c1 = i3 - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;
  assign y  = c3 >>> SHIFT;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    sat_data = y[WIDTH-1:0];
    sat_flag = 1'b0;
    if (y > Y_MAX) begin
      sat_data = Y_MAX[WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (y < Y_MIN) begin
      sat_data = Y_MIN[WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every right-hand
  // side reads the pre-edge value (i2 <= i2 + i1 sees the old i1).
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state     <= PRIME;
      prime_cnt <= '0;
      phase     <= '0;
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_sat     <= 1'b0;
    end else begin
      if (beat) begin
        i1    <= i1 + x;
        i2    <= i2 + i1;
        i3    <= i3 + i2;
        phase <= (phase == PHASE_LAST) ? '0 : phase + LR'(1);
      end

      if (m_valid && axis.m_axis_data_tready)
        m_valid <= 1'b0;

      if (dec_ev) begin
        d1 <= i3;
        d2 <= c1;
        d3 <= c2;
        case (state)
          PRIME: begin
            if (prime_cnt == 2'd2) begin
              state     <= RUN;
              prime_cnt <= '0;
            end else begin
              prime_cnt <= prime_cnt + 2'd1;
            end
          end
          RUN: begin
            // A fresh sample overrides the consume-clear above.
            m_data  <= sat_data;
            m_sat   <= sat_flag;
            m_valid <= 1'b1;
          end
          default: state <= PRIME;
        endcase
      end
    end
  end

  assign axis.s_axis_data_tready = s_ready;
  assign axis.m_axis_data_tdata  = m_data;
  assign axis.m_axis_data_tvalid = m_valid;
  assign axis.m_axis_data_tsat   = m_sat;
endmodule

// File: tb/tb_cic3_decimator.sv
// -----------------------------------------------------------------------------
// tb_cic3_decimator
// Directed bench for cic3_decimator (WIDTH=16, DECIM=64). Expected samples are
// hand-derived sinc^3 steady-state values: gain R^3 = 2^18 times the mean of
// the bipolar input, shifted right by 3 and clipped to 16 bits.
//   all ones       -> 2^15 clipped to 32767, tsat=1
//   all zeros      -> -32768, tsat=0
//   1,0,1,0,...    -> 0
//   1,1,1,0 repeat -> mean 1/2 -> 16384
// -----------------------------------------------------------------------------
module tb_cic3_decimator;
  localparam int WIDTH = 16;
  localparam int DECIM = 64;

  logic aclk = 1'b0;
  logic arst = 1'b1;
  always #5 aclk = ~aclk;

  cic3_decimator_if #(.WIDTH(WIDTH)) bus ();

  cic3_decimator #(.WIDTH(WIDTH), .DECIM(DECIM)) dut (
    .aclk (aclk),
    .arst (arst),
    .axis (bus)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: counts accepted beats and records consumed samples together with
  // the number of beats accepted before the consuming edge.
  int acc_cnt = 0;
  int smp_data[$];
  int smp_sat[$];
  int smp_acc[$];

  initial begin
    forever begin
      @(negedge aclk);
      if (!arst) begin
        if (bus.m_axis_data_tvalid && bus.m_axis_data_tready) begin
          smp_data.push_back(int'($signed(bus.m_axis_data_tdata)));
          smp_sat.push_back(int'(bus.m_axis_data_tsat));
          smp_acc.push_back(acc_cnt);
        end
        if (bus.s_axis_data_tvalid && bus.s_axis_data_tready)
          acc_cnt = acc_cnt + 1;
      end
    end
  end

  int base  = 0;
  int qbase = 0;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic pat(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (idx % 2) == 0;
      default: return (idx % 4) != 3;
    endcase
  endfunction

  // Entered and left at posedge+1.
  task automatic do_reset();
    arst = 1'b1;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tdata  = 1'b0;
    bus.m_axis_data_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    arst  = 1'b0;
    base  = acc_cnt;
    qbase = smp_data.size();
  endtask

  // Feed n accepted beats of a pattern with the given valid duty (percent).
  task automatic drive(input int n, input int mode, input int duty);
    int target;
    int budget;
    int cyc;
    target = acc_cnt + n;
    budget = n * 20 + 50;
    cyc    = 0;
    while (acc_cnt < target && cyc < budget) begin
      bus.s_axis_data_tvalid = ($urandom_range(99) < duty);
      bus.s_axis_data_tdata  = pat(mode, acc_cnt - base);
      @(posedge aclk);
      #1;
      cyc++;
    end
    bus.s_axis_data_tvalid = 1'b0;
    if (acc_cnt < target) check("drive_timeout", acc_cnt, target);
  endtask

  task automatic check_run(input string tag, input int n_exp, input int val,
                           input int sat, input bit chk_lat);
    repeat (3) @(posedge aclk);
    #1;
    check($sformatf("%s_count", tag), smp_data.size() - qbase, n_exp);
    for (int i = qbase; i < smp_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i - qbase), smp_data[i], val);
      check($sformatf("%s_sat%0d", tag, i - qbase), smp_sat[i], sat);
      if (chk_lat)
        check($sformatf("%s_lat%0d", tag, i - qbase), smp_acc[i] - base,
              4 * DECIM + (i - qbase) * DECIM);
    end
  endtask

  initial begin
    int ready_low;
    int viol;
    bit seen;

    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tdata  = 1'b0;
    bus.m_axis_data_tready = 1'b1;

    // Reset state
    do_reset();
    check("rst_tvalid", int'(bus.m_axis_data_tvalid), 0);
    check("rst_tdata", int'(bus.m_axis_data_tdata), 0);
    check("rst_tsat", int'(bus.m_axis_data_tsat), 0);
    check("rst_tready", int'(bus.s_axis_data_tready), 1);

    // Dense runs, 8 blocks each: 3 silent priming blocks then 5 samples
    drive(8 * DECIM, 0, 100);
    check_run("ones", 5, 32767, 1, 1'b1);

    do_reset();
    drive(8 * DECIM, 1, 100);
    check_run("zeros", 5, -32768, 0, 1'b1);

    do_reset();
    drive(8 * DECIM, 2, 100);
    check_run("alt", 5, 0, 0, 1'b1);

    do_reset();
    drive(8 * DECIM, 3, 100);
    check_run("dense34", 5, 16384, 0, 1'b1);

    // Sparse input: same values and count as the dense run
    do_reset();
    drive(8 * DECIM, 3, 30);
    check_run("sparse34", 5, 16384, 0, 1'b1);

    // Backpressure: stall output for 200 cycles while the input keeps coming
    do_reset();
    drive(266, 0, 100);
    check("bp_first", smp_data.size() - qbase, 1);
    bus.m_axis_data_tready = 1'b0;
    ready_low = 0;
    viol      = 0;
    seen      = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.s_axis_data_tvalid = 1'b1;
      bus.s_axis_data_tdata  = 1'b1;
      if (!bus.s_axis_data_tready) begin
        ready_low++;
        if ((acc_cnt - base) % DECIM != DECIM - 1) viol++;
      end
      if (seen && (!bus.m_axis_data_tvalid ||
                   $signed(bus.m_axis_data_tdata) != 16'sd32767 ||
                   !bus.m_axis_data_tsat))
        viol++;
      if (bus.m_axis_data_tvalid) seen = 1'b1;
      @(posedge aclk);
      #1;
    end
    check("bp_viol", viol, 0);
    check("bp_ready_low", ready_low, 83);
    check("bp_beats", acc_cnt - base, 383);
    check("bp_hold_valid", int'(bus.m_axis_data_tvalid), 1);
    check("bp_hold_data", int'($signed(bus.m_axis_data_tdata)), 32767);
    check("bp_hold_tready", int'(bus.s_axis_data_tready), 0);
    bus.m_axis_data_tready = 1'b1;
    @(posedge aclk);
    #1;
    check("bp_release_count", smp_data.size() - qbase, 2);
    check("bp_release_beats", acc_cnt - base, 384);
    check("bp_release_valid", int'(bus.m_axis_data_tvalid), 1);
    drive(128, 0, 100);
    check_run("bp", 5, 32767, 1, 1'b0);

    // Asynchronous reset mid-block at phase 17 with a pending sample
    do_reset();
    bus.m_axis_data_tready = 1'b0;
    drive(4 * DECIM + 17, 0, 100);
    check("arst_pre_valid", int'(bus.m_axis_data_tvalid), 1);
    #3;
    arst = 1'b1;
    #1;
    check("arst_tvalid", int'(bus.m_axis_data_tvalid), 0);
    check("arst_tdata", int'(bus.m_axis_data_tdata), 0);
    check("arst_tsat", int'(bus.m_axis_data_tsat), 0);
    @(posedge aclk);
    #1;
    arst  = 1'b0;
    base  = acc_cnt;
    qbase = smp_data.size();
    bus.m_axis_data_tready = 1'b1;
    drive(4 * DECIM - 1, 0, 100);
    repeat (2) @(posedge aclk);
    #1;
    check("arst_quiet_count", smp_data.size() - qbase, 0);
    check("arst_quiet_valid", int'(bus.m_axis_data_tvalid), 0);
    drive(1, 0, 100);
    check("arst_first_valid", int'(bus.m_axis_data_tvalid), 1);
    check("arst_first_data", int'($signed(bus.m_axis_data_tdata)), 32767);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
